axi_rr_arb_slice: RTL and testbench
===================================

# axi_rr_arb_slice

Round-robin arbitration node with a one-entry output register, used inside the AXI interconnect arbitration trees for the AR, AW, W, B and R channels. It selects one of N_MASTER requesters per accepted beat. Fairness comes from an internal rotating priority pointer that advances on each granted last beat. The winner's payload, source index and last flag are registered toward the next tree level or the target port. Burst lock keeps multi-beat transfers from one source contiguous.

## Interface
- N_MASTER, 4: number of requesters; minimum 1.
- DATA_WIDTH, 32: payload width per requester.
- ID_WIDTH, max(1, $clog2(N_MASTER)): width of source index and RR pointer.
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset, asynchronous active-low.
- req_i  in  N_MASTER  per-source valid.
- data_i  in  N_MASTER*DATA_WIDTH  payloads, source k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- last_i  in  N_MASTER  per-source last-beat flag.
- gnt_o  out  N_MASTER  one-hot grant (ready) per source, combinational.
- valid_o  out  1  output register holds a beat.
- data_o  out  DATA_WIDTH  registered payload.
- id_o  out  ID_WIDTH  registered source index of data_o.
- last_o  out  1  registered last flag.
- ready_i  in  1  downstream accepts the beat held in the output register.

## Operation
- Reset (async, rst_n=0): valid_o=0, data_o=0, id_o=0, last_o=0, rr_q=0, state=UNLOCKED, lock_id_q=0. Reset mid-burst discards the held beat and any lock with no further output.
- Slot free: free = !valid_o || ready_i.
- Winner, state UNLOCKED: first k with req_i[k]=1, searching rr_q, rr_q+1, ..., N_MASTER-1, 0, ..., rr_q-1.
- Winner, state LOCKED: lock_id_q, only if req_i[lock_id_q]=1. All other requests are ignored.
- gnt_o[winner]=free. All other gnt_o bits are 0. gnt_o is always at most one-hot. Accept = any gnt_o bit set.
- On accept: data_o/last_o are loaded from the winner, id_o=winner, valid_o=1.
- When ready_i && valid_o && !accept: valid_o goes to 0. data_o, id_o and last_o hold their stale values.
- FSM transitions:
  - UNLOCKED -> LOCKED when an accepted beat has last=0; lock_id_q=winner.
  - LOCKED -> UNLOCKED when an accepted beat has last=1.
  - All other cases: state is held.
- Pointer: on an accepted beat with last=1, rr_q = (winner+1) mod N_MASTER. The pointer wraps N_MASTER-1 -> 0, including non-power-of-two N. The pointer is not updated on non-last beats.
- If the locked source drops req_i, the node stalls: no grant, lock held. This is legal; it must not deadlock once the source resumes.
- N_MASTER=1: rr_q stays 0 and id_o stays 0.

## Timing
- Latency: a beat accepted in cycle t appears on valid_o/data_o in cycle t+1.
- Throughput: one beat per cycle while ready_i=1.
- ready_i -> gnt_o is a combinational path. req_i -> gnt_o is combinational through the priority search.
- Simultaneous drain and load in the same cycle: the new beat replaces the old one, and valid_o stays 1.
- Output beat stability: while valid_o=1 and ready_i=0, data_o, id_o and last_o hold stable.

## Structure
- Package axi_arb_pkg holds the lock state typedef (enum UNLOCKED, LOCKED) and a function next_rr(ptr, n) implementing modulo increment. These are shared with other tree nodes.
- Sub-module axi_rr_prio_enc: combinational rotating priority encoder. Inputs req and rr_q; outputs found and winner index. It is reused by the non-registered tree nodes.
- Top level contains the lock FSM, rr_q, the output register and grant gating.

## Test plan
- Reset then req_i=4'b1111, all last=1, ready_i=1: grants go 0,1,2,3,0 on consecutive cycles, and id_o follows one cycle later.
- N_MASTER=3, req_i=3'b111, last=1: id_o sequence 0,1,2,0; rr_q wraps from 2 to 0, never reaching 3.
- Source 1 sends a 3-beat burst (last=0,0,1) while sources 0 and 2 request: no gnt to 0 or 2 until source 1's last beat is accepted; the next grant goes to 2.
- valid_o=1, ready_i=0 for 5 cycles with all requests high: gnt_o=0 and data_o stable. When ready_i rises, a new beat loads in the same cycle it is released.
- Locked source 2 drops req_i for 3 cycles mid-burst: no grants; it resumes and completes; the pointer then advances to 3.
- Assert rst_n=0 asynchronously while LOCKED with valid_o=1: valid_o drops immediately. After release, arbitration restarts from index 0, unlocked.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared definitions for the AXI arbitration tree nodes: the burst-lock
// state type and the modulo increment used by round-robin pointers.
package axi_arb_pkg;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    // Advance a round-robin pointer by one, wrapping at n (works for any n >= 1).
    function automatic int unsigned next_rr(input int unsigned ptr, input int unsigned n);
        if (ptr + 1 >= n) begin
            return 0;
        end
        return ptr + 1;
    endfunction

endpackage

// File: rtl/axi_rr_prio_enc.sv
// Rotating priority encoder: returns the first requester found when searching
// upward from rr_i and wrapping at N_MASTER. Purely combinational.
module axi_rr_prio_enc
    import axi_arb_pkg::*;
#(
    parameter int N_MASTER = 4,
    parameter int ID_WIDTH = (N_MASTER > 1) ? $clog2(N_MASTER) : 1
) (
    input  logic [N_MASTER-1:0] req_i,
    input  logic [ID_WIDTH-1:0] rr_i,
    output logic                found_o,
    output logic [ID_WIDTH-1:0] winner_o
);

    // One extra bit so rr + offset never overflows before the wrap subtraction.
    logic [ID_WIDTH:0]   sum   [N_MASTER];
    logic [ID_WIDTH-1:0] rot_idx [N_MASTER];

    // Source index examined at each search offset from the pointer.
    for (genvar gi = 0; gi < N_MASTER; gi++) begin : g_rot
        assign sum[gi]     = {1'b0, rr_i} + (ID_WIDTH+1)'(gi);
        assign rot_idx[gi] = (sum[gi] >= (ID_WIDTH+1)'(N_MASTER))
                           ? ID_WIDTH'(sum[gi] - (ID_WIDTH+1)'(N_MASTER))
                           : sum[gi][ID_WIDTH-1:0];
    end

    // Scan from the farthest offset down so the nearest requester wins.
    always_comb begin
        found_o  = 1'b0;
        winner_o = '0;
        for (int i = N_MASTER - 1; i >= 0; i--) begin
            if (req_i[rot_idx[i]]) begin
                found_o  = 1'b1;
                winner_o = rot_idx[i];
            end
        end
    end

endmodule

// File: rtl/axi_rr_arb_slice.sv
// Round-robin arbitration node with a one-entry output register. Multi-beat
// bursts lock the grant to their source until the last beat is accepted; the
// priority pointer moves past the winner only on last beats.
module axi_rr_arb_slice
    import axi_arb_pkg::*;
#(
    parameter int N_MASTER   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = (N_MASTER > 1) ? $clog2(N_MASTER) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_MASTER-1:0]            req_i,
    input  logic [N_MASTER*DATA_WIDTH-1:0] data_i,
    input  logic [N_MASTER-1:0]            last_i,
    output logic [N_MASTER-1:0]            gnt_o,
    output logic                           valid_o,
    output logic [DATA_WIDTH-1:0]          data_o,
    output logic [ID_WIDTH-1:0]            id_o,
    output logic                           last_o,
    input  logic                           ready_i
);

    lock_state_e           state_q, state_d;
    logic [ID_WIDTH-1:0]   lock_id_q, lock_id_d;
    logic [ID_WIDTH-1:0]   rr_q, rr_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic                  last_q, last_d;

    logic                  enc_found;
    logic [ID_WIDTH-1:0]   enc_winner;
    logic                  win_found;
    logic [ID_WIDTH-1:0]   win_id;
    logic [DATA_WIDTH-1:0] win_data;
    logic                  win_last;
    logic                  free;
    logic                  accept;

    axi_rr_prio_enc #(
        .N_MASTER (N_MASTER),
        .ID_WIDTH (ID_WIDTH)
    ) u_prio_enc (
        .req_i    (req_i),
        .rr_i     (rr_q),
        .found_o  (enc_found),
        .winner_o (enc_winner)
    );

    // The output slot can take a beat when empty or being drained this cycle.
    assign free   = !valid_q || ready_i;
    assign accept = win_found && free;

    // Select the winner: the locked source only, otherwise the encoder's pick.
    always_comb begin
        win_found = enc_found;
        win_id    = enc_winner;
        if (state_q == LOCKED) begin
            win_found = req_i[lock_id_q];
            win_id    = lock_id_q;
        end
    end

    // Mux the winner's payload and last flag.
    always_comb begin
        win_data = '0;
        win_last = 1'b0;
        for (int k = 0; k < N_MASTER; k++) begin
            if (win_id == ID_WIDTH'(k)) begin
                win_data = data_i[k*DATA_WIDTH +: DATA_WIDTH];
                win_last = last_i[k];
            end
        end
    end

    // Grant is one-hot on the winner, gated by slot availability.
    for (genvar gi = 0; gi < N_MASTER; gi++) begin : g_gnt
        assign gnt_o[gi] = accept && (win_id == ID_WIDTH'(gi));
    end

    // Lock FSM, pointer and output-register next state.
    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        rr_d      = rr_q;
        valid_d   = valid_q;
        data_d    = data_q;
        id_d      = id_q;
        last_d    = last_q;
        if (accept) begin
            valid_d = 1'b1;
            data_d  = win_data;
            id_d    = win_id;
            last_d  = win_last;
            if (win_last) begin
                state_d = UNLOCKED;
                rr_d    = ID_WIDTH'(next_rr(32'(win_id), N_MASTER));
            end else if (state_q == UNLOCKED) begin
                state_d   = LOCKED;
                lock_id_d = win_id;
            end
        end else if (ready_i && valid_q) begin
            // Drained with nothing to replace it; payload fields keep stale values.
            valid_d = 1'b0;
        end
    end

    // State registers; reset discards any held beat and any lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= UNLOCKED;
            lock_id_q <= '0;
            rr_q      <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            id_q      <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            rr_q      <= rr_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            id_q      <= id_d;
            last_q    <= last_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign id_o    = id_q;
    assign last_o  = last_q;

endmodule

// File: tb/tb_axi_rr_arb_slice.sv
// Bench for axi_rr_arb_slice: a 4-source node driven from a vector table
// with a beat scoreboard, plus a 3-source node for pointer wrap and
// hand-written async reset sequence.
module tb_axi_rr_arb_slice;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_i, last_i, gnt_o;
    logic [N*DW-1:0] data_i;
    logic            ready_i, valid_o, last_o;
    logic [DW-1:0]   data_o;
    logic [IW-1:0]   id_o;

    logic [2:0]      req3, lst3, gnt3;
    logic [3*DW-1:0] dat3;
    logic            rdy3, val3, lst3_o;
    logic [DW-1:0]   dat3_o;
    logic [1:0]      id3_o;

    always #5 clk = ~clk;

    axi_rr_arb_slice #(.N_MASTER(N), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .data_i(data_i), .last_i(last_i),
        .gnt_o(gnt_o), .valid_o(valid_o), .data_o(data_o), .id_o(id_o),
        .last_o(last_o), .ready_i(ready_i)
    );

    axi_rr_arb_slice #(.N_MASTER(3), .DATA_WIDTH(DW)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_i(req3), .data_i(dat3), .last_i(lst3),
        .gnt_o(gnt3), .valid_o(val3), .data_o(dat3_o), .id_o(id3_o),
        .last_o(lst3_o), .ready_i(rdy3)
    );

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] last;
        logic       rdy;
        logic [3:0] gnt;
    } vec_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [IW-1:0] id;
        logic          last;
    } beat_t;

    vec_t  vt[$];
    beat_t sb[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    cyc   = 0;

    logic          exp_valid = 1'b0;
    logic [DW-1:0] exp_data  = '0;
    logic [IW-1:0] exp_id    = '0;
    logic          exp_last  = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // Called just after a rising edge: drive, check grant, then check the
    // registered beat one cycle later against the scoreboard.
    task automatic apply(input vec_t v, input string nm);
        bit    pushed;
        beat_t b;
        int    w;
        cyc++;
        req_i   = v.req;
        last_i  = v.last;
        ready_i = v.rdy;
        for (int k = 0; k < N; k++) begin
            data_i[k*DW +: DW] = {8'(k), 8'hA5, 16'(cyc)};
        end
        #4;
        chk({nm, ".gnt"}, 64'(gnt_o), 64'(v.gnt));
        pushed = 1'b0;
        if (v.gnt != 4'b0000) begin
            w = oh_idx(v.gnt);
            sb.push_back('{data: data_i[w*DW +: DW], id: IW'(w), last: v.last[w]});
            pushed = 1'b1;
        end
        @(posedge clk);
        #1;
        if (pushed) begin
            b = sb.pop_front();
            exp_valid = 1'b1;
            exp_data  = b.data;
            exp_id    = b.id;
            exp_last  = b.last;
            chk({nm, ".valid"}, 64'(valid_o), 64'(1));
            chk({nm, ".data"},  64'(data_o),  64'(exp_data));
            chk({nm, ".id"},    64'(id_o),    64'(exp_id));
            chk({nm, ".last"},  64'(last_o),  64'(exp_last));
        end else if (v.rdy) begin
            exp_valid = 1'b0;
            chk({nm, ".drain"}, 64'(valid_o), 64'(0));
        end else begin
            chk({nm, ".hold_valid"}, 64'(valid_o), 64'(exp_valid));
            if (exp_valid) begin
                chk({nm, ".hold_data"}, 64'(data_o), 64'(exp_data));
                chk({nm, ".hold_id"},   64'(id_o),   64'(exp_id));
            end
        end
        $display("vec %s req=%b last=%b rdy=%b gnt=%b valid=%b id=%0d data=%h",
                 nm, v.req, v.last, v.rdy, gnt_o, valid_o, id_o, data_o);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] id3_exp [5];
        vec_t       rv;
        id3_exp = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};

        // Main table: RR rotation, gaps, burst lock, backpressure, lock stall.
        vt.push_back('{4'b1111, 4'b1111, 1'b1, 4'b0001});
        vt.push_back('{4'b1111, 4'b1111, 1'b1, 4'b0010});
        vt.push_back('{4'b1111, 4'b1111, 1'b1, 4'b0100});
        vt.push_back('{4'b1111, 4'b1111, 1'b1, 4'b1000});
        vt.push_back('{4'b1111, 4'b1111, 1'b1, 4'b0001});
        vt.push_back('{4'b0000, 4'b1111, 1'b1, 4'b0000});
        vt.push_back('{4'b1100, 4'b1111, 1'b1, 4'b0100});
        vt.push_back('{4'b0101, 4'b1111, 1'b1, 4'b0001});
        vt.push_back('{4'b0111, 4'b1101, 1'b1, 4'b0010});   // burst from 1 begins
        vt.push_back('{4'b0111, 4'b1101, 1'b1, 4'b0010});
        vt.push_back('{4'b0111, 4'b1111, 1'b1, 4'b0010});   // last beat
        vt.push_back('{4'b0101, 4'b1111, 1'b1, 4'b0100});   // next goes to 2
        vt.push_back('{4'b1111, 4'b1111, 1'b1, 4'b1000});
        for (int i = 0; i < 5; i++) begin
            vt.push_back('{4'b1111, 4'b1111, 1'b0, 4'b0000}); // backpressure
        end
        vt.push_back('{4'b1111, 4'b1111, 1'b1, 4'b0001});   // release + load
        vt.push_back('{4'b1101, 4'b1011, 1'b1, 4'b0100});   // lock on 2
        for (int i = 0; i < 3; i++) begin
            vt.push_back('{4'b1011, 4'b1111, 1'b1, 4'b0000}); // 2 stalls
        end
        vt.push_back('{4'b1111, 4'b1011, 1'b1, 4'b0100});
        vt.push_back('{4'b1111, 4'b1111, 1'b1, 4'b0100});   // unlock
        vt.push_back('{4'b1111, 4'b1111, 1'b1, 4'b1000});   // pointer at 3
        vt.push_back('{4'b0000, 4'b1111, 1'b1, 4'b0000});

        rst_n   = 1'b0;
        req_i   = '0;
        last_i  = '0;
        data_i  = '0;
        ready_i = 1'b0;
        req3    = '0;
        lst3    = '0;
        rdy3    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            dat3[k*DW +: DW] = 32'h300 + 32'(k);
        end

        #2;
        chk("rst.valid", 64'(valid_o), 64'(0));
        chk("rst.data",  64'(data_o),  64'(0));
        chk("rst.id",    64'(id_o),    64'(0));
        chk("rst.last",  64'(last_o),  64'(0));
        chk("rst.gnt",   64'(gnt_o),   64'(0));
        chk("rst3.valid", 64'(val3),   64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Three-source node: pointer wraps 2 -> 0.
        req3 = 3'b111;
        lst3 = 3'b111;
        rdy3 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #4;
            chk($sformatf("n3[%0d].gnt", i), 64'(gnt3), 64'(3'b001 << id3_exp[i]));
            @(posedge clk);
            #1;
            chk($sformatf("n3[%0d].id", i),    64'(id3_o),  64'(id3_exp[i]));
            chk($sformatf("n3[%0d].valid", i), 64'(val3),   64'(1));
            chk($sformatf("n3[%0d].data", i),  64'(dat3_o), 64'(32'h300 + 32'(id3_exp[i])));
            $display("n3 beat %0d gnt=%b id=%0d", i, gnt3, id3_o);
        end
        req3 = '0;

        for (int i = 0; i < vt.size(); i++) begin
            apply(vt[i], $sformatf("v%0d", i));
        end

        // Async reset while locked with a held beat.
        rv = '{4'b0010, 4'b0000, 1'b0, 4'b0010};
        apply(rv, "lock1");
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.valid", 64'(valid_o), 64'(0));
        chk("arst.id",    64'(id_o),    64'(0));
        chk("arst.data",  64'(data_o),  64'(0));
        chk("arst.last",  64'(last_o),  64'(0));
        $display("async reset asserted valid=%b id=%0d", valid_o, id_o);
        sb.delete();
        exp_valid = 1'b0;
        exp_data  = '0;
        exp_id    = '0;
        exp_last  = 1'b0;
        req_i     = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rv = '{4'b1111, 4'b1111, 1'b1, 4'b0001};
        apply(rv, "post_rst0");
        rv = '{4'b1111, 4'b1111, 1'b1, 4'b0010};
        apply(rv, "post_rst1");

        chk("sb.empty", 64'(sb.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
